// File: rtl/arith_enc_pkg.sv
// Shared constants and the output token type for the AV1 arithmetic encoder stages.
// Pure declarations: no latency, no flow control.
package arith_enc_pkg;

   localparam int EC_MIN_PROB   = 4;
   localparam int EC_PROB_SHIFT = 6;
   localparam int CDF_PROB_TOP  = 32768;
   localparam int TOK_RANGE_W   = 16;
   localparam int TOK_D_W       = 5;

   localparam logic [TOK_RANGE_W-1:0] RANGE_INIT = 16'h8000;

   typedef struct packed {
      logic [TOK_RANGE_W-1:0] low_add;
      logic [TOK_D_W-1:0]     shift;
      logic [TOK_RANGE_W-1:0] range;
      logic                   last;
   } tok_t;

endpackage

// File: rtl/arith_norm_lzc.sv
// Leading-one detector: d = (WIDTH-1) - floor(log2 val); zero input yields d = 0.
// Combinational, no flow control.
module arith_norm_lzc #(
   parameter int WIDTH = 16,
   parameter int D_W   = 5
) (
   input  logic [WIDTH-1:0] val,
   output logic [D_W-1:0]   d
);

   // Ascending scan so the highest set bit is the last one to write d.
   always_comb begin
      d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (val[i]) d = D_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/arith_range_update.sv
// AV1 range-update stage: one symbol per cycle, 1-cycle accept-to-out_valid latency; stalls
// (in_ready=0, state frozen) while out_valid && !out_ready. ARITH_BOOL_EN adds the in_bool path.
module arith_range_update
   import arith_enc_pkg::*;
#(
   parameter int RANGE_WIDTH = 16,
   parameter int D_SIZE      = 5,
   parameter int SYM_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
`ifdef ARITH_BOOL_EN
   input  logic                   in_bool,
`endif
   input  logic [SYM_WIDTH-1:0]   in_symbol,
   input  logic [SYM_WIDTH-1:0]   in_n,
   input  logic [RANGE_WIDTH-1:0] in_fl,
   input  logic [RANGE_WIDTH-1:0] in_fh,
   input  logic                   in_last,
   output logic [2*SYM_WIDTH-1:0] lut_addr,
   input  logic [RANGE_WIDTH-1:0] lut_q,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [RANGE_WIDTH-1:0] out_low_add,
   output logic [D_SIZE-1:0]      out_shift,
   output logic [RANGE_WIDTH-1:0] out_range,
   output logic                   out_last,
   output logic                   err
);

   localparam int PW = 2*RANGE_WIDTH - 8 - EC_PROB_SHIFT;
   localparam logic [RANGE_WIDTH-1:0] MIN_PROB = RANGE_WIDTH'(EC_MIN_PROB);

   logic [RANGE_WIDTH-1:0] rng;
   logic [PW-1:0]          pl_full, ph_full;
   logic [RANGE_WIDTH-1:0] pl, ph;
   logic [RANGE_WIDTH-1:0] u, v, r_new, low_add, rng_norm;
   logic [D_SIZE-1:0]      d;
   logic                   illegal;
   logic                   in_fire;
   tok_t                   tok, tok_nxt;
   logic                   unused_bits;

   assign lut_addr = {in_n, in_symbol};
   assign in_ready = !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;

   // 8-bit range top times 10-bit probability; the halved product always fits the range width.
   assign pl_full = PW'(rng[RANGE_WIDTH-1:8]) * PW'(in_fl[RANGE_WIDTH-1:EC_PROB_SHIFT]);
   assign ph_full = PW'(rng[RANGE_WIDTH-1:8]) * PW'(in_fh[RANGE_WIDTH-1:EC_PROB_SHIFT]);
   assign pl      = pl_full[RANGE_WIDTH:1];
   assign ph      = ph_full[RANGE_WIDTH:1];

   always_comb begin
      u       = rng;
      v       = '0;
      r_new   = '0;
      low_add = '0;
      illegal = 1'b0;
`ifdef ARITH_BOOL_EN
      if (in_bool) begin
         v = ph + MIN_PROB;
         if (in_symbol[0]) begin
            low_add = rng - v;
            r_new   = v;
         end else begin
            r_new   = rng - v;
         end
      end else
`endif
      begin
         v = ph + lut_q - MIN_PROB;
         if (!in_fl[RANGE_WIDTH-1]) begin
            u       = pl + lut_q;
            low_add = rng - u;
         end
         r_new   = u - v;
         illegal = (lut_q == '0);
      end
   end

   arith_norm_lzc #(
      .WIDTH (RANGE_WIDTH),
      .D_W   (D_SIZE)
   ) u_lzc (
      .val (r_new),
      .d   (d)
   );

   assign rng_norm = r_new << d;

   // An illegal symbol still produces a token so downstream sees one token per input.
   always_comb begin
      tok_nxt.last = in_last;
      if (illegal) begin
         tok_nxt.low_add = '0;
         tok_nxt.shift   = '0;
         tok_nxt.range   = rng;
      end else begin
         tok_nxt.low_add = low_add;
         tok_nxt.shift   = d;
         tok_nxt.range   = rng_norm;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid     <= 1'b0;
         tok.low_add   <= '0;
         tok.shift     <= '0;
         tok.range     <= RANGE_INIT;
         tok.last      <= 1'b0;
         rng           <= RANGE_INIT;
         err           <= 1'b0;
      end else if (in_fire) begin
         out_valid <= 1'b1;
         tok       <= tok_nxt;
         if (illegal) err <= 1'b1;
         else         rng <= rng_norm;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign out_low_add = tok.low_add;
   assign out_shift   = tok.shift;
   assign out_range   = tok.range;
   assign out_last    = tok.last;

   assign unused_bits = ^{pl_full[PW-1], pl_full[0], ph_full[PW-1], ph_full[0],
                          in_fl[EC_PROB_SHIFT-1:0], in_fh[EC_PROB_SHIFT-1:0]};

endmodule

// File: tb/tb_arith_range_update.sv
// Bench for arith_range_update: directed vector table, hand sequences for stall/reset/bool,
// then randomized traffic checked against an integer reference model.
module tb_arith_range_update;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_last;
   logic [3:0]  in_symbol, in_n;
   logic [15:0] in_fl, in_fh, lut_q;
   logic [7:0]  lut_addr;
   logic        out_valid, out_ready, out_last, err;
   logic [15:0] out_low_add, out_range;
   logic [4:0]  out_shift;
`ifdef ARITH_BOOL_EN
   logic        bool_sel;
`endif

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   arith_range_update dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
`ifdef ARITH_BOOL_EN
      .in_bool     (bool_sel),
`endif
      .in_symbol   (in_symbol),
      .in_n        (in_n),
      .in_fl       (in_fl),
      .in_fh       (in_fh),
      .in_last     (in_last),
      .lut_addr    (lut_addr),
      .lut_q       (lut_q),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_low_add (out_low_add),
      .out_shift   (out_shift),
      .out_range   (out_range),
      .out_last    (out_last),
      .err         (err)
   );

   // Model of the external lut_u_module: 4*(N-s+1), or 0 when s > N.
   function automatic logic [15:0] lut_model(input logic [7:0] a);
      int n, s;
      n = int'(a[7:4]);
      s = int'(a[3:0]);
      if (s > n) return 16'd0;
      return 16'(4 * (n - s + 1));
   endfunction

   assign lut_q = lut_model(lut_addr);

   typedef struct {
      int low;
      int shift;
      int rng;
      bit last;
      bit err;
   } exp_t;

   typedef struct {
      logic [3:0]  n, s;
      logic [15:0] fl, fh;
      logic        last;
      int          e_low, e_shift, e_range;
      bit          e_err;
   } vec_t;

   // Reference: plain integer arithmetic from the encoder equations, renormalised by doubling.
   function automatic exp_t model(input int r, input int n, input int s, input int fl,
                                  input int fh, input bit b, input bit last, input bit err_in);
      exp_t e;
      int pl, ph, q, u, v, rn, sh;
      pl = ((r / 256) * (fl / 64)) / 2;
      ph = ((r / 256) * (fh / 64)) / 2;
      q  = (s > n) ? 0 : 4 * (n - s + 1);
      e.last = last;
      e.err  = err_in;
      if (b) begin
         v = ph + 4;
         if (s % 2 == 1) begin e.low = r - v; rn = v;     end
         else            begin e.low = 0;     rn = r - v; end
      end else if (q == 0) begin
         e.low = 0; e.shift = 0; e.rng = r; e.err = 1'b1;
         return e;
      end else begin
         v = ph + q - 4;
         if (fl >= 32768) begin u = r;      e.low = 0;     end
         else             begin u = pl + q; e.low = r - u; end
         rn = u - v;
      end
      sh = 0;
      while (rn > 0 && rn < 32768) begin
         rn = rn * 2;
         sh++;
      end
      e.shift = sh;
      e.rng   = rn;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] n, input logic [3:0] s, input logic [15:0] fl,
                        input logic [15:0] fh, input logic last, input logic b);
      in_n      = n;
      in_symbol = s;
      in_fl     = fl;
      in_fh     = fh;
      in_last   = last;
`ifdef ARITH_BOOL_EN
      bool_sel  = b;
`else
      if (b) $display("bool stimulus ignored in this build");
`endif
      in_valid  = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      exp_t q[$];
      exp_t e, got;
      int   model_rng;
      bit   model_err;
      bit   fire_in;
      bit   bm;
      int   rn, rs, rfl, rfh;

      vecs[0] = '{n:4'd1, s:4'd0, fl:16'd32768, fh:16'd16384, last:1'b0,
                  e_low:0,     e_shift:2, e_range:65520, e_err:1'b0};
      vecs[1] = '{n:4'd1, s:4'd1, fl:16'd16384, fh:16'd0,     last:1'b1,
                  e_low:32876, e_shift:1, e_range:65288, e_err:1'b0};
      vecs[2] = '{n:4'd0, s:4'd1, fl:16'd16384, fh:16'd0,     last:1'b0,
                  e_low:0,     e_shift:0, e_range:65288, e_err:1'b1};
      vecs[3] = '{n:4'd2, s:4'd2, fl:16'd8192,  fh:16'd0,     last:1'b1,
                  e_low:48964, e_shift:2, e_range:65296, e_err:1'b1};

      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(4'd3, 4'd2, 16'd0, 16'd0, 1'b0, 1'b0);
      in_valid  = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();

      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_range", out_range, 16'h8000);
      chk("reset_low_add", out_low_add, 0);
      chk("reset_shift", out_shift, 0);
      chk("reset_last", out_last, 0);
      chk("reset_err", err, 0);
      chk("reset_in_ready", in_ready, 1);
      chk("lut_addr", lut_addr, 8'h32);

      // Back-to-back vectors: each accept coincides with the previous token draining.
      for (int i = 0; i < 4; i++) begin
         drive(vecs[i].n, vecs[i].s, vecs[i].fl, vecs[i].fh, vecs[i].last, 1'b0);
         #1;
         chk("vec_in_ready", in_ready, 1);
         tick();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_low_add", i), out_low_add, vecs[i].e_low);
         chk($sformatf("vec%0d_shift", i), out_shift, vecs[i].e_shift);
         chk($sformatf("vec%0d_range", i), out_range, vecs[i].e_range);
         chk($sformatf("vec%0d_last", i), out_last, vecs[i].last);
         chk($sformatf("vec%0d_err", i), err, vecs[i].e_err);
      end
      tick();
      chk("drain_valid", out_valid, 0);

      // Token in flight under backpressure, then reset clears everything.
      drive(4'd1, 4'd0, 16'd32768, 16'd16384, 1'b1, 1'b0);
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("inflight_valid", out_valid, 1);
      reset_pulse();
      chk("midreset_valid", out_valid, 0);
      chk("midreset_low_add", out_low_add, 0);
      chk("midreset_shift", out_shift, 0);
      chk("midreset_range", out_range, 16'h8000);
      chk("midreset_last", out_last, 0);
      chk("midreset_err", err, 0);

      // Stall for three cycles with a pending input, then release.
      out_ready = 1'b1;
      drive(4'd1, 4'd0, 16'd32768, 16'd16384, 1'b0, 1'b0);
      tick();
      drive(4'd1, 4'd1, 16'd16384, 16'd0, 1'b1, 1'b0);
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_in_ready", in_ready, 0);
         chk("stall_valid", out_valid, 1);
         chk("stall_range", out_range, 65520);
         chk("stall_shift", out_shift, 2);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("release_valid", out_valid, 1);
      chk("release_low_add", out_low_add, 32876);
      chk("release_shift", out_shift, 1);
      chk("release_range", out_range, 65288);
      chk("release_last", out_last, 1);
      tick();
      chk("single_token", out_valid, 0);

`ifdef ARITH_BOOL_EN
      // Bool symbol with an address that would be illegal for the LUT: err must stay clear.
      reset_pulse();
      drive(4'd0, 4'd1, 16'd0, 16'd16384, 1'b0, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("bool_low_add", out_low_add, 16380);
      chk("bool_shift", out_shift, 1);
      chk("bool_range", out_range, 32776);
      chk("bool_err", err, 0);
      bool_sel = 1'b0;
`endif

      // Randomized traffic against the reference model.
      reset_pulse();
      model_rng = 32768;
      model_err = 1'b0;
      fire_in   = 1'b0;
      in_valid  = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!in_valid || fire_in) begin
            if (cyc < 2900 && $urandom_range(0, 3) != 0) begin
               bm = 1'b0;
`ifdef ARITH_BOOL_EN
               bm = ($urandom_range(0, 3) == 0);
`endif
               rn = $urandom_range(0, 15);
               rs = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, rn);
               if (bm) begin
                  rfl = $urandom_range(0, 32768);
                  rfh = $urandom_range(0, 30000);
               end else if (rs == 0) begin
                  rfl = 32768;
                  rfh = $urandom_range(0, 30000);
               end else begin
                  rfl = $urandom_range(1, 30000);
                  rfh = $urandom_range(0, rfl - 1);
               end
               drive(4'(rn), 4'(rs), 16'(rfl), 16'(rfh), 1'($urandom_range(0, 1)), bm);
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         fire_in = in_valid && in_ready;
         if (out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin
               failed++;
               $display("FAIL rand_spurious: token low=%0d range=%0d with nothing expected",
                        out_low_add, out_range);
            end else begin
               e = q.pop_front();
               got.low = int'(out_low_add); got.shift = int'(out_shift);
               got.rng = int'(out_range);   got.last  = out_last;   got.err = err;
               if (got.low !== e.low || got.shift !== e.shift || got.rng !== e.rng ||
                   got.last !== e.last || got.err !== e.err) begin
                  failed++;
                  $display("FAIL rand_token: got low=%0d sh=%0d rng=%0d last=%0d err=%0d, expected low=%0d sh=%0d rng=%0d last=%0d err=%0d",
                           got.low, got.shift, got.rng, got.last, got.err,
                           e.low, e.shift, e.rng, e.last, e.err);
               end
            end
         end
         if (fire_in) begin
            bm = 1'b0;
`ifdef ARITH_BOOL_EN
            bm = bool_sel;
`endif
            e = model(model_rng, int'(in_n), int'(in_symbol), int'(in_fl), int'(in_fh),
                      bm, in_last, model_err);
            model_err = e.err;
            model_rng = e.rng;
            q.push_back(e);
         end
         tick();
      end
      chk("rand_queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
